// File: rtl/sync_fifo_flex_if.sv
// Handshake bundle for sync_fifo_flex: producer/consumer controls plus
// occupancy, threshold and error status returned by the FIFO.
interface sync_fifo_flex_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;
    logic             clr_err;

    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with standard or first-word-fall-through read, occupancy
// count, programmable almost flags and sticky overflow/underflow errors.
module sync_fifo_flex #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = 0
) (
    input logic             sys_clk,
    input logic             rst,
    sync_fifo_flex_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("sync_fifo_flex: WIDTH must be >= 1");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sync_fifo_flex: DEPTH must be a power of two >= 2");
        end
        if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
            $error("sync_fifo_flex: AF_THRESH must lie in 1..DEPTH");
        end
        if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
            $error("sync_fifo_flex: AE_THRESH must lie in 0..DEPTH-1");
        end
        if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
            $error("sync_fifo_flex: FWFT must be 0 or 1");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    count_q;
    logic             full_w;
    logic             empty_w;
    logic             wr_acc;
    logic             rd_acc;
    logic             overflow_q;
    logic             underflow_q;

    // Accepts look only at registered status, so a full FIFO refuses a write
    // even when a read frees a slot on the same edge.
    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);
    assign wr_acc  = bus.wr_en & ~full_w;
    assign rd_acc  = bus.rd_en & ~empty_w;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_acc) mem[wr_ptr[AW-1:0]] <= bus.wr_data;
    end

    // A new error event outranks a clear arriving on the same edge.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= (overflow_q  & ~bus.clr_err) | (bus.wr_en & full_w);
            underflow_q <= (underflow_q & ~bus.clr_err) | (bus.rd_en & empty_w);
        end
    end

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    generate
        if (FWFT == 1) begin : g_fwft
            assign bus.rd_data  = mem[rd_ptr[AW-1:0]];
            assign bus.rd_valid = ~empty_w;
        end else begin : g_std
            logic [WIDTH-1:0] rd_data_q;
            logic             rd_valid_q;

            always_ff @(posedge sys_clk) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= mem[rd_ptr[AW-1:0]];
                end
            end

            assign bus.rd_data  = rd_data_q;
            assign bus.rd_valid = rd_valid_q;
        end
    endgenerate
endmodule
